// File: rtl/square_plotter.sv
// Square pixel sequencer: walks a 20x20 / 10x10 / 4x4 square in raster order, one pixel per clock.
// Latency: first pixel registered 1 cycle after accept; done pulses one cycle after the last pixel.
// No backpressure: the adapter must take a pixel every cycle. Optional clipping via SQUARE_PLOTTER_CLIP_EN.
module square_plotter #(
    parameter int X_W      = 9,
    parameter int Y_W      = 8,
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  logic [1:0]     size,
    input  logic [X_W-1:0] x_in,
    input  logic [Y_W-1:0] y_in,
    input  logic [2:0]     colour_in,
    output logic           busy,
    output logic           done,
    output logic [X_W-1:0] vga_x,
    output logic [Y_W-1:0] vga_y,
    output logic [2:0]     vga_colour,
    output logic           plot
);

`ifdef SQUARE_PLOTTER_CLIP_EN
    localparam bit CLIP_ON = 1'b1;
`else
    localparam bit CLIP_ON = 1'b0;
`endif

    // Screen limits widened by one bit so the compare sees the untruncated sum.
    localparam logic [X_W:0] SCR_W = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0] SCR_H = (Y_W+1)'(SCREEN_H);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DRAW = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [X_W-1:0] ox_q;
    logic [Y_W-1:0] oy_q;
    logic [2:0]     col_q;
    logic [4:0]     side_q;
    logic [4:0]     cx_q;
    logic [4:0]     cy_q;

    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           plot_q, plot_d;
    logic [X_W-1:0] vga_x_q, vga_x_d;
    logic [Y_W-1:0] vga_y_q, vga_y_d;
    logic [2:0]     vga_colour_q, vga_colour_d;

    logic [4:0]     side_req;
    logic [4:0]     side_m1;
    logic           accept;
    logic           last_col;
    logic           last_row;
    logic [X_W:0]   x_full;
    logic [Y_W:0]   y_full;
    logic           in_screen;

    // Decode the requested size class into a side length; 0 marks the reserved code.
    always_comb begin
        side_req = 5'd0;
        case (size)
            2'b00:   side_req = 5'd20;
            2'b01:   side_req = 5'd10;
            2'b10:   side_req = 5'd4;
            default: side_req = 5'd0;
        endcase
    end

    assign accept    = (state_q != S_DRAW) && start && (size != 2'b11);
    assign side_m1   = side_q - 5'd1;
    assign last_col  = (cx_q == side_m1);
    assign last_row  = (cy_q == side_m1);
    assign x_full    = {1'b0, ox_q} + (X_W+1)'(cx_q);
    assign y_full    = {1'b0, oy_q} + (Y_W+1)'(cy_q);
    assign in_screen = (x_full < SCR_W) && (y_full < SCR_H);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic: DONE behaves like IDLE for start sampling so squares can chain.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_DRAW;
            S_DRAW:  if (last_col && last_row) state_d = S_DONE;
            S_DONE:  state_d = accept ? S_DRAW : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output next-values: coordinates hold whenever no pixel is being issued.
    always_comb begin
        busy_d       = 1'b0;
        done_d       = 1'b0;
        plot_d       = 1'b0;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
        case (state_q)
            S_DRAW: begin
                busy_d       = 1'b1;
                plot_d       = !CLIP_ON || in_screen;
                vga_x_d      = x_full[X_W-1:0];
                vga_y_d      = y_full[Y_W-1:0];
                vga_colour_d = col_q;
            end
            S_DONE:  done_d = 1'b1;
            default: ;
        endcase
    end

    // Request latch and raster offset counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            ox_q   <= '0;
            oy_q   <= '0;
            col_q  <= '0;
            side_q <= '0;
            cx_q   <= '0;
            cy_q   <= '0;
        end else if (accept) begin
            ox_q   <= x_in;
            oy_q   <= y_in;
            col_q  <= colour_in;
            side_q <= side_req;
            cx_q   <= '0;
            cy_q   <= '0;
        end else if (state_q == S_DRAW) begin
            if (last_col) begin
                cx_q <= '0;
                cy_q <= last_row ? 5'd0 : cy_q + 5'd1;
            end else begin
                cx_q <= cx_q + 5'd1;
            end
        end
    end

    // Registered outputs to the adapter.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            plot_q       <= 1'b0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
        end else begin
            busy_q       <= busy_d;
            done_q       <= done_d;
            plot_q       <= plot_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign plot       = plot_q;
    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;

endmodule
